// File: rtl/ws_pkg.sv
// ---------------------------------------------------------------------------
// ws_pkg
// Shared definitions for the weight-stationary array output path.
//   DEFAULT_PSUM_W : default partial-sum width used by the sink and its banks
//   sink_state_t   : psum_sink control states (CAPTURE, DRAIN)
// ---------------------------------------------------------------------------
package ws_pkg;

    localparam int DEFAULT_PSUM_W = 32;

    typedef enum logic {
        CAPTURE = 1'b0,
        DRAIN   = 1'b1
    } sink_state_t;

endpackage

// File: rtl/psum_row_bank.sv
// ---------------------------------------------------------------------------
// psum_row_bank
// One row's partial-sum storage: DEPTH x PSUM_W, one write port, one read
// port. The read is registered, and its output register only updates on
// rd_en, so it doubles as the holding register for the beat on display.
//   clk, rst_n : clock, synchronous active-low reset (read register only)
//   wr_en      : write strobe, wr_addr / wr_data
//   rd_en      : read strobe, rd_addr; rd_data valid the cycle after
// ---------------------------------------------------------------------------
module psum_row_bank
    import ws_pkg::*;
#(
    parameter int DEPTH  = 16,
    parameter int PSUM_W = DEFAULT_PSUM_W
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     wr_en,
    input  logic [$clog2(DEPTH)-1:0] wr_addr,
    input  logic [PSUM_W-1:0]        wr_data,
    input  logic                     rd_en,
    input  logic [$clog2(DEPTH)-1:0] rd_addr,
    output logic [PSUM_W-1:0]        rd_data
);

    logic [PSUM_W-1:0] mem_q [DEPTH];
    logic [PSUM_W-1:0] rd_data_q;
    logic [PSUM_W-1:0] rd_data_d;

    // NOTE: storage has no reset; stale words stay hidden because the
    // top-level entry counts are cleared, and a reset here would stop the
    // array mapping onto RAM.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem_q[wr_addr] <= wr_data;
        end
    end

    // NOTE: combinational blocks use blocking '=' with a default first, so
    // no path leaves a variable unassigned and no latch is inferred.
    always_comb begin
        rd_data_d = rd_data_q;
        if (rd_en) begin
            rd_data_d = mem_q[rd_addr];
        end
    end

    // NOTE: clocked blocks use non-blocking '<=' so every flop samples the
    // pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rd_data_q <= '0;
        end else begin
            rd_data_q <= rd_data_d;
        end
    end

    assign rd_data = rd_data_q;

endmodule

// File: rtl/psum_sink.sv
// ---------------------------------------------------------------------------
// psum_sink
// Captures the skewed per-row partial-sum stream from the array controller
// into per-row banks, then on done_in drains every captured entry row-major
// over a valid/ready stream.
//   psum_valid/psum_addr/psum_data : per-row write strobe, address, data
//   done_in                        : starts the drain
//   out_valid/out_ready            : output handshake
//   out_data/out_row/out_idx       : beat payload and its position
//   out_last                       : final beat of the drain
//   drain_done                     : one-cycle pulse after the final beat
//   busy                           : high while draining
//   err                            : sticky; out-of-range or mid-drain write
// ---------------------------------------------------------------------------
module psum_sink
    import ws_pkg::*;
#(
    parameter int ARRAY_ROWS = 3,
    parameter int PSUM_W     = DEFAULT_PSUM_W,
    parameter int DEPTH      = 16
) (
    input  logic                              clk,
    input  logic                              rst_n,
    input  logic [0:ARRAY_ROWS-1]             psum_valid,
    input  logic [0:ARRAY_ROWS-1][31:0]       psum_addr,
    input  logic [0:ARRAY_ROWS-1][PSUM_W-1:0] psum_data,
    input  logic                              done_in,
    output logic                              out_valid,
    input  logic                              out_ready,
    output logic [PSUM_W-1:0]                 out_data,
    output logic [$clog2(ARRAY_ROWS)-1:0]     out_row,
    output logic [$clog2(DEPTH)-1:0]          out_idx,
    output logic                              out_last,
    output logic                              drain_done,
    output logic                              busy,
    output logic                              err
);

    localparam int AW    = $clog2(DEPTH);
    localparam int RW    = $clog2(ARRAY_ROWS);
    localparam int CNT_W = AW + 1;          // must be able to hold DEPTH

    typedef logic [ARRAY_ROWS-1:0][CNT_W-1:0] cnt_vec_t;

    typedef struct packed {
        logic          found;
        logic [RW-1:0] row;
        logic [AW-1:0] idx;
    } pos_t;

    // First captured entry at or after (start_row, start_idx) in row-major
    // order. Each row holds indices 0..cnt-1, so a later row starts at 0.
    function automatic pos_t seek(input cnt_vec_t         cnt,
                                  input logic [RW-1:0]    start_row,
                                  input logic [CNT_W-1:0] start_idx);
        pos_t p;
        p = '0;
        // Walk downwards so the lowest matching row is the one kept.
        for (int r = ARRAY_ROWS - 1; r >= 0; r--) begin
            if (RW'(r) == start_row && start_idx < cnt[r]) begin
                p.found = 1'b1;
                p.row   = RW'(r);
                p.idx   = start_idx[AW-1:0];
            end else if (RW'(r) > start_row && cnt[r] != '0) begin
                p.found = 1'b1;
                p.row   = RW'(r);
                p.idx   = '0;
            end
        end
        return p;
    endfunction

    // True when no captured entry follows (row, idx).
    function automatic logic is_last(input cnt_vec_t      cnt,
                                     input logic [RW-1:0] row,
                                     input logic [AW-1:0] idx);
        logic later;
        later = 1'b0;
        for (int r = 0; r < ARRAY_ROWS; r++) begin
            if (RW'(r) == row && ({1'b0, idx} + CNT_W'(1)) < cnt[r]) begin
                later = 1'b1;
            end else if (RW'(r) > row && cnt[r] != '0) begin
                later = 1'b1;
            end
        end
        return !later;
    endfunction

    sink_state_t        state_q, state_d;
    cnt_vec_t           cnt_q, cnt_d;
    logic               out_valid_q, out_valid_d;
    logic               out_last_q, out_last_d;
    logic [RW-1:0]      out_row_q, out_row_d;
    logic [AW-1:0]      out_idx_q, out_idx_d;
    logic               drain_done_q, drain_done_d;
    logic               err_q, err_d;

    pos_t               first_pos, next_pos;
    logic               handshake, load_first, advance, finish;
    logic [RW-1:0]      rd_row;
    logic [AW-1:0]      rd_idx;
    logic               rd_last;
    logic [CNT_W-1:0]   wr_cnt;

    logic [ARRAY_ROWS-1:0]             bank_wr_en;
    logic [ARRAY_ROWS-1:0]             bank_rd_en;
    logic [ARRAY_ROWS-1:0][PSUM_W-1:0] bank_rd_data;

    // -----------------------------------------------------------------
    // Drain sequencing. A bank read is issued for the first entry on the
    // first DRAIN cycle and for the following entry on every accepted beat,
    // so the bank read register presents the next beat right at the edge
    // where the current one is consumed (full rate, no bubbles).
    // -----------------------------------------------------------------
    always_comb begin
        first_pos  = seek(cnt_q, '0, '0);
        next_pos   = seek(cnt_q, out_row_q, {1'b0, out_idx_q} + CNT_W'(1));
        handshake  = out_valid_q && out_ready;
        // out_valid_q is low in DRAIN only on the entry cycle.
        load_first = (state_q == DRAIN) && !out_valid_q && first_pos.found;
        advance    = handshake && next_pos.found;
        finish     = (state_q == DRAIN) &&
                     ((!out_valid_q && !first_pos.found) ||
                      (handshake && !next_pos.found));
        rd_row     = load_first ? first_pos.row : next_pos.row;
        rd_idx     = load_first ? first_pos.idx : next_pos.idx;
        rd_last    = is_last(cnt_q, rd_row, rd_idx);
    end

    // -----------------------------------------------------------------
    // State register
    // -----------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q      <= CAPTURE;
            cnt_q        <= '0;
            out_valid_q  <= 1'b0;
            out_last_q   <= 1'b0;
            out_row_q    <= '0;
            out_idx_q    <= '0;
            drain_done_q <= 1'b0;
            err_q        <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            out_valid_q  <= out_valid_d;
            out_last_q   <= out_last_d;
            out_row_q    <= out_row_d;
            out_idx_q    <= out_idx_d;
            drain_done_q <= drain_done_d;
            err_q        <= err_d;
        end
    end

    // -----------------------------------------------------------------
    // Next-state logic
    // -----------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        case (state_q)
            CAPTURE: if (done_in) state_d = DRAIN;
            DRAIN:   if (finish)  state_d = CAPTURE;
        endcase
    end

    // -----------------------------------------------------------------
    // Capture, counts, and output beat registers
    // -----------------------------------------------------------------
    always_comb begin
        cnt_d        = cnt_q;
        err_d        = err_q;
        bank_wr_en   = '0;
        bank_rd_en   = '0;
        wr_cnt       = '0;
        out_valid_d  = out_valid_q;
        out_last_d   = out_last_q;
        out_row_d    = out_row_q;
        out_idx_d    = out_idx_q;
        drain_done_d = 1'b0;

        // Rows are independent. Writes in the done_in cycle still land
        // because the state is CAPTURE until the following edge.
        for (int r = 0; r < ARRAY_ROWS; r++) begin
            if (psum_valid[r]) begin
                if (state_q == CAPTURE && psum_addr[r] < 32'(DEPTH)) begin
                    bank_wr_en[r] = 1'b1;
                    wr_cnt = {1'b0, psum_addr[r][AW-1:0]} + CNT_W'(1);
                    // A rewrite of an existing entry leaves the count alone.
                    if (wr_cnt > cnt_d[r]) begin
                        cnt_d[r] = wr_cnt;
                    end
                end else begin
                    err_d = 1'b1;
                end
            end
        end

        if (load_first || advance) begin
            for (int r = 0; r < ARRAY_ROWS; r++) begin
                if (RW'(r) == rd_row) begin
                    bank_rd_en[r] = 1'b1;
                end
            end
            out_valid_d = 1'b1;
            out_row_d   = rd_row;
            out_idx_d   = rd_idx;
            out_last_d  = rd_last;
        end

        if (finish) begin
            out_valid_d  = 1'b0;
            out_last_d   = 1'b0;
            cnt_d        = '0;
            drain_done_d = 1'b1;
        end
    end

    // -----------------------------------------------------------------
    // Row banks
    // -----------------------------------------------------------------
    for (genvar g = 0; g < ARRAY_ROWS; g++) begin : g_bank
        psum_row_bank #(
            .DEPTH  (DEPTH),
            .PSUM_W (PSUM_W)
        ) u_bank (
            .clk     (clk),
            .rst_n   (rst_n),
            .wr_en   (bank_wr_en[g]),
            .wr_addr (psum_addr[g][AW-1:0]),
            .wr_data (psum_data[g]),
            .rd_en   (bank_rd_en[g]),
            .rd_addr (rd_idx),
            .rd_data (bank_rd_data[g])
        );
    end

    // The addressed bank's read register holds the beat while stalled.
    always_comb begin
        out_data = '0;
        for (int r = 0; r < ARRAY_ROWS; r++) begin
            if (RW'(r) == out_row_q) begin
                out_data = bank_rd_data[r];
            end
        end
    end

    assign out_valid  = out_valid_q;
    assign out_last   = out_last_q;
    assign out_row    = out_row_q;
    assign out_idx    = out_idx_q;
    assign drain_done = drain_done_q;
    assign busy       = (state_q == DRAIN);
    assign err        = err_q;

endmodule

// File: tb/tb_psum_sink.sv
// ---------------------------------------------------------------------------
// tb_psum_sink
// Directed bench for psum_sink (3 rows, 32-bit psums, depth 16). Inputs are
// driven and outputs sampled on the falling clock edge.
// ---------------------------------------------------------------------------
module tb_psum_sink;

    logic             clk;
    logic             rst_n;
    logic [0:2]       psum_valid;
    logic [0:2][31:0] psum_addr;
    logic [0:2][31:0] psum_data;
    logic             done_in;
    logic             out_valid;
    logic             out_ready;
    logic [31:0]      out_data;
    logic [1:0]       out_row;
    logic [3:0]       out_idx;
    logic             out_last;
    logic             drain_done;
    logic             busy;
    logic             err;

    typedef struct {
        int row;
        int idx;
        int data;
    } beat_t;

    beat_t exp_q[$];
    int    n_checks = 0;
    int    n_errors = 0;
    logic [3:0] rdy_pat = 4'b1001;  // index 0..3 -> ready 1,0,0,1

    psum_sink #(
        .ARRAY_ROWS (3),
        .PSUM_W     (32),
        .DEPTH      (16)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .psum_valid (psum_valid),
        .psum_addr  (psum_addr),
        .psum_data  (psum_data),
        .done_in    (done_in),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_data   (out_data),
        .out_row    (out_row),
        .out_idx    (out_idx),
        .out_last   (out_last),
        .drain_done (drain_done),
        .busy       (busy),
        .err        (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", tag, obs, obs, exp, exp);
        end
    endtask

    task automatic set_wr(input int r, input logic [31:0] a, input logic [31:0] d);
        psum_valid[r] = 1'b1;
        psum_addr[r]  = a;
        psum_data[r]  = d;
    endtask

    // Controller-style skew: row r writes addr 0..2 on cycles r+3..r+5.
    task automatic skew_capture();
        repeat (3) @(negedge clk);
        for (int c = 0; c < 5; c++) begin
            for (int r = 0; r < 3; r++) begin
                if (c >= r && c <= r + 2) set_wr(r, 32'(c - r), 32'(100 * r + (c - r)));
                else psum_valid[r] = 1'b0;
            end
            @(negedge clk);
        end
        psum_valid = '0;
    endtask

    task automatic skew_expect();
        exp_q.delete();
        for (int r = 0; r < 3; r++)
            for (int i = 0; i < 3; i++)
                exp_q.push_back('{r, i, 100 * r + i});
    endtask

    // Pulse done_in for one cycle; any writes already set up ride along.
    task automatic pulse_done();
        done_in = 1'b1;
        @(negedge clk);
        done_in    = 1'b0;
        psum_valid = '0;
        check("busy_after_done", busy, 1);
        check("valid_after_done", out_valid, 0);
    endtask

    task automatic expect_empty_drain();
        pulse_done();
        check("empty_done_early", drain_done, 0);
        @(negedge clk);
        check("empty_drain_done", drain_done, 1);
        check("empty_busy", busy, 0);
        check("empty_valid", out_valid, 0);
        @(negedge clk);
        check("empty_done_len", drain_done, 0);
    endtask

    // Consume the drain, comparing every displayed beat against exp_q.
    task automatic collect(input bit stall, input int max_cyc);
        int got;
        int last_hs;
        bit pending;
        got = 0;
        last_hs = -10;
        pending = 1'b0;
        for (int cyc = 0; cyc < max_cyc; cyc++) begin
            out_ready = stall ? rdy_pat[cyc % 4] : 1'b1;
            if (drain_done) begin
                check("done_after_last", 32'(cyc - last_hs), 1);
                check("beat_count", 32'(got), 32'(exp_q.size()));
                check("busy_at_done", busy, 0);
                check("valid_at_done", out_valid, 0);
                out_ready = 1'b1;
                @(negedge clk);
                check("done_pulse_len", drain_done, 0);
                return;
            end
            if (pending) check("valid_held", out_valid, 1);
            if (out_valid) begin
                if (got >= exp_q.size()) begin
                    check("extra_beat", 32'(got), 32'(exp_q.size()));
                end else begin
                    check("beat_row", 32'(out_row), 32'(exp_q[got].row));
                    check("beat_idx", 32'(out_idx), 32'(exp_q[got].idx));
                    check("beat_data", out_data, 32'(exp_q[got].data));
                    check("beat_last", 32'(out_last), 32'(got == exp_q.size() - 1));
                end
                if (out_ready) begin
                    if (!stall && got > 0) check("no_bubble", 32'(cyc - last_hs), 1);
                    got++;
                    last_hs = cyc;
                    pending = 1'b0;
                end else begin
                    pending = 1'b1;
                end
            end
            @(negedge clk);
        end
        check("drain_timeout", drain_done, 1);
        out_ready = 1'b1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n      = 1'b0;
        psum_valid = '0;
        psum_addr  = '0;
        psum_data  = '0;
        done_in    = 1'b0;
        out_ready  = 1'b1;
        repeat (2) @(negedge clk);

        // Reset state
        check("rst_valid", out_valid, 0);
        check("rst_last", out_last, 0);
        check("rst_done", drain_done, 0);
        check("rst_busy", busy, 0);
        check("rst_err", err, 0);
        check("rst_data", out_data, 0);
        check("rst_row", 32'(out_row), 0);
        check("rst_idx", 32'(out_idx), 0);
        rst_n = 1'b1;

        // 1: skewed capture, full-rate drain of 9 beats
        skew_capture();
        skew_expect();
        pulse_done();
        @(negedge clk);
        check("first_valid_latency", out_valid, 1);
        collect(1'b0, 40);

        // 2: same capture, ready pattern 1,0,0,1
        skew_capture();
        skew_expect();
        pulse_done();
        collect(1'b1, 80);

        // 3: only row 1 writes; second write lands in the done_in cycle
        set_wr(1, 32'd0, 32'h11);
        @(negedge clk);
        set_wr(1, 32'd1, 32'h22);
        pulse_done();
        exp_q.delete();
        exp_q.push_back('{1, 0, 32'h11});
        exp_q.push_back('{1, 1, 32'h22});
        collect(1'b0, 30);

        // 4: overwrite, out-of-range drops, then an empty drain
        check("err_before_oob", err, 0);
        set_wr(2, 32'd0, 32'h4FF);
        @(negedge clk);
        psum_valid = '0;
        set_wr(2, 32'd0, 32'h500);
        set_wr(0, 32'h0001_0000, 32'hBAD);
        @(negedge clk);
        psum_valid = '0;
        set_wr(2, 32'd16, 32'hDEAD);
        @(negedge clk);
        psum_valid = '0;
        set_wr(2, 32'd1, 32'h501);
        @(negedge clk);
        psum_valid = '0;
        check("err_after_oob", err, 1);
        pulse_done();
        exp_q.delete();
        exp_q.push_back('{2, 0, 32'h500});
        exp_q.push_back('{2, 1, 32'h501});
        collect(1'b0, 30);
        expect_empty_drain();

        // 5: reset after the 4th beat of a 6-beat drain
        for (int i = 0; i < 6; i++) begin
            set_wr(0, 32'(i), 32'(10 + i));
            @(negedge clk);
        end
        psum_valid = '0;
        pulse_done();
        @(negedge clk);
        for (int k = 0; k < 4; k++) begin
            check("pre_rst_valid", out_valid, 1);
            check("pre_rst_idx", 32'(out_idx), 32'(k));
            check("pre_rst_data", out_data, 32'(10 + k));
            @(negedge clk);
        end
        rst_n = 1'b0;
        @(negedge clk);
        check("mid_rst_valid", out_valid, 0);
        check("mid_rst_busy", busy, 0);
        check("mid_rst_done", drain_done, 0);
        check("mid_rst_err", err, 0);
        rst_n = 1'b1;
        @(negedge clk);
        check("post_rst_done", drain_done, 0);
        expect_empty_drain();

        // 6: writes attempted during DRAIN are dropped and flag err
        set_wr(0, 32'd0, 32'h61);
        @(negedge clk);
        set_wr(0, 32'd1, 32'h62);
        @(negedge clk);
        psum_valid = '0;
        check("err_before_drain_wr", err, 0);
        pulse_done();
        set_wr(0, 32'd0, 32'hFFFF);
        set_wr(1, 32'd0, 32'hEEEE);
        @(negedge clk);
        psum_valid = '0;
        exp_q.delete();
        exp_q.push_back('{0, 0, 32'h61});
        exp_q.push_back('{0, 1, 32'h62});
        collect(1'b0, 30);
        check("err_after_drain_wr", err, 1);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/psum_sink.md
# psum_sink

Output-side responder for the weight-stationary array controller. It captures the skewed per-row partial-sum stream qualified by the controller's `psum_valid`/`psum_addr` strobes into per-row banks. On the controller's `done` pulse it drains all captured results row-major over a valid/ready stream to the host or DMA. It sits between the PE array's bottom-edge psum outputs and the output memory path.

## Interface
- `ARRAY_ROWS`, 3, number of PE rows; one psum lane and one bank per row
- `PSUM_W`, 32, psum data width
- `DEPTH`, 16, entries per row bank; power of two, ≥2

Ports:
- `clk`  in  1  clock; single clock domain
- `rst_n`  in  1  reset, synchronous, active-low
- `psum_valid`  in  [0:ARRAY_ROWS-1]  per-row write strobe from the controller
- `psum_addr`  in  [0:ARRAY_ROWS-1][31:0]  per-row write address from the controller; only bits `[$clog2(DEPTH)-1:0]` index the bank
- `psum_data`  in  [0:ARRAY_ROWS-1][PSUM_W-1:0]  per-row psum from the array's bottom edge
- `done_in`  in  1  one-cycle controller `done` pulse; starts the drain
- `out_valid`  out  1  output beat valid
- `out_ready`  in  1  downstream accept
- `out_data`  out  PSUM_W  psum value
- `out_row`  out  $clog2(ARRAY_ROWS)  source row of the beat
- `out_idx`  out  $clog2(DEPTH)  entry index within the row
- `out_last`  out  1  marks the final beat of the drain
- `drain_done`  out  1  one-cycle pulse when the drain completes
- `busy`  out  1  high while in DRAIN
- `err`  out  1  sticky error; cleared only by reset

## Operation
States are CAPTURE and DRAIN. Reset enters CAPTURE.

- CAPTURE, per row r with `psum_valid[r]`=1:
  - If `psum_addr[r]` < DEPTH: write `psum_data[r]` to bank r at that address, and set `cnt[r]` = max(`cnt[r]`, addr+1).
  - If `psum_addr[r]` ≥ DEPTH (full 32-bit compare): drop the write and set `err`.
- All rows write independently in the same cycle.
- A duplicate address overwrites the entry; `cnt` is unchanged.
- CAPTURE → DRAIN when `done_in`=1. Writes presented in that same cycle are still accepted.
- DRAIN order:
  - Rows ascending, indices 0..`cnt[r]`-1.
  - Rows with `cnt`=0 are skipped.
  - `out_last` is high on the final beat.
- DRAIN end:
  - The cycle after the last handshake: state returns to CAPTURE, all `cnt` clear to 0, and `drain_done` pulses.
  - If every `cnt` is 0, DRAIN emits no beats and pulses `drain_done` one cycle after entry.
- DRAIN ignores `done_in`. Any `psum_valid` during DRAIN is dropped and sets `err`.
- Bank contents are never cleared. Stale entries are hidden because `cnt` is zero.

## Timing
- Reset values: state=CAPTURE, all `cnt`=0, and `out_valid`, `out_last`, `drain_done`, `busy`, `err` all 0.
- `out_data`, `out_row`, `out_idx` reset to 0.
- Bank write takes effect at the `clk` edge where the strobe is sampled.
- Bank read has 1-cycle registered latency.
- Drain latency:
  - `done_in` sampled at edge t: `busy`=1 from t+1, first `out_valid` at t+2.
  - With `out_ready` held high, one beat per cycle, no bubbles, including across row boundaries and skipped rows.
- Handshake:
  - A beat transfers when `out_valid && out_ready`.
  - While `out_valid && !out_ready`, all `out_*` hold stable.
  - `out_valid` never drops without a handshake.
- Reset mid-drain: at the next edge with `rst_n`=0, `out_valid` drops, state returns to CAPTURE and counts clear; no `drain_done` is produced.
- `cnt` width is $clog2(DEPTH)+1 so it can hold the value DEPTH.

## Structure
- Shared package `ws_pkg`: state enum `sink_state_t` (CAPTURE, DRAIN) and default `PSUM_W`.
- Sub-module `psum_row_bank`: 1 write port, 1 read port, DEPTH×PSUM_W, registered read, instantiated ARRAY_ROWS times.
- Top level holds the FSM, the `cnt` registers, the drain row/index pointer, and an output holding register with prefetch so drain runs at full rate.

## Test plan
- Controller-style skew on 3 rows, row r writes addr 0..2 at cycles r+3..r+5 with data 100·r+addr; `done_in` pulse → 9 beats in order (0,0)=0, (0,1)=1 … (2,2)=202, `out_last` on the 9th, `drain_done` the following cycle.
- Same capture with `out_ready` toggling 1,0,0,1 → no lost or duplicated beats, and `out_*` stable while stalled.
- Only row 1 writes addr 0..1 → exactly 2 beats, (1,0) and (1,1); rows 0 and 2 skipped.
- `psum_addr`=16 with DEPTH=16 → write dropped, `err`=1, and the beat count excludes it. `done_in` with no prior writes → zero beats, `drain_done` one cycle after entry.
- `rst_n` low for 1 cycle after the 4th beat → `out_valid`=0 next cycle. A following `done_in` with no new writes gives zero beats.
- `psum_valid` asserted during DRAIN → `err`=1, and the drained data is unchanged.
